// File: rtl/seg7_frame_capture.sv
// seg7_frame_capture: samples a multiplexed 7-segment bus (segments plus
// one-hot digit selects) and rebuilds the displayed BCD value of every digit.
// Each digit must be stable for STABLE_CYCLES samples before it is committed
// to a shadow slot. A full shadow set is handed out as one frame over a
// valid/ready handshake. Sticky flags report unknown patterns and dropped frames.
// Optional build macro SEG7_DP_CAPTURE_EN adds frame_dp, which carries the
// decimal-point bit of each digit along with the frame.
module seg7_frame_capture #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     dig_sel,
  output logic [4*NUM_DIGITS-1:0]   frame_digits,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic                      err_pattern,
  output logic                      err_overflow,
  input  logic                      err_clr
`ifdef SEG7_DP_CAPTURE_EN
  ,
  output logic [NUM_DIGITS-1:0]     frame_dp
`endif
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);
  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_BAD   = 4'hF;

  // Map a {a..g} pattern to its BCD code. Blank gets its own code.
  // Anything else is flagged with CODE_BAD.
  function automatic logic [3:0] seg_decode(input logic [6:0] p);
    logic [3:0] c;
    case (p)
      7'b1111110: c = 4'd0;
      7'b0110000: c = 4'd1;
      7'b1101101: c = 4'd2;
      7'b1111001: c = 4'd3;
      7'b0110011: c = 4'd4;
      7'b1011011: c = 4'd5;
      7'b1011111: c = 4'd6;
      7'b1110000: c = 4'd7;
      7'b1111111: c = 4'd8;
      7'b1111011: c = 4'd9;
      7'b0000000: c = CODE_BLANK;
      default:    c = CODE_BAD;
    endcase
    return c;
  endfunction

  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [6:0]              prev_seg_q, prev_seg_d;
  logic [NUM_DIGITS-1:0]   prev_sel_q, prev_sel_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    commit_q, commit_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] frame_digits_q, frame_digits_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    err_pattern_q, err_pattern_d;
  logic                    err_overflow_q, err_overflow_d;

  logic       one_hot, changed, do_commit, complete, load;
  logic [3:0] code;

  // Stability tracking, commit into shadow slots and frame hand-off.
  // The commit uses the previous sample. A saturated counter guarantees that
  // this sample was the one seen stable, even if the pins move on this edge.
  always_comb begin
    seg_d          = seg_in;
    sel_d          = dig_sel;
    prev_seg_d     = seg_q[7:1];
    prev_sel_d     = sel_q;
    one_hot        = $onehot(sel_q);
    changed        = (seg_q[7:1] != prev_seg_q) || (sel_q != prev_sel_q);
    do_commit      = (cnt_q == STABLE_C) && !commit_q;
    code           = seg_decode(prev_seg_q);
    complete       = &seen_q;
    load           = complete && (!frame_valid_q || frame_ready);

    cnt_d          = cnt_q;
    if (!one_hot)               cnt_d = 8'd0;
    else if (changed)           cnt_d = 8'd1;
    else if (cnt_q < STABLE_C)  cnt_d = cnt_q + 8'd1;

    commit_d       = changed ? 1'b0 : (commit_q | do_commit);

    shadow_d       = shadow_q;
    seen_d         = complete ? '0 : seen_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (do_commit && prev_sel_q[i]) begin
        shadow_d[4*i +: 4] = code;
        seen_d[i]          = 1'b1;
      end
    end

    frame_digits_d = load ? shadow_q : frame_digits_q;
    frame_valid_d  = frame_valid_q;
    if (load)                             frame_valid_d = 1'b1;
    else if (frame_valid_q && frame_ready) frame_valid_d = 1'b0;

    err_pattern_d  = err_clr ? 1'b0
                   : (err_pattern_q | (do_commit && (code == CODE_BAD)));
    err_overflow_d = err_clr ? 1'b0
                   : (err_overflow_q | (complete && frame_valid_q && !frame_ready));
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q          <= '0;
      sel_q          <= '0;
      prev_seg_q     <= '0;
      prev_sel_q     <= '0;
      cnt_q          <= '0;
      commit_q       <= 1'b0;
      shadow_q       <= '0;
      seen_q         <= '0;
      frame_digits_q <= {NUM_DIGITS{CODE_BLANK}};
      frame_valid_q  <= 1'b0;
      err_pattern_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      seg_q          <= seg_d;
      sel_q          <= sel_d;
      prev_seg_q     <= prev_seg_d;
      prev_sel_q     <= prev_sel_d;
      cnt_q          <= cnt_d;
      commit_q       <= commit_d;
      shadow_q       <= shadow_d;
      seen_q         <= seen_d;
      frame_digits_q <= frame_digits_d;
      frame_valid_q  <= frame_valid_d;
      err_pattern_q  <= err_pattern_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign frame_digits = frame_digits_q;
  assign frame_valid  = frame_valid_q;
  assign err_pattern  = err_pattern_q;
  assign err_overflow = err_overflow_q;

`ifdef SEG7_DP_CAPTURE_EN
  logic                  prev_dp_q, prev_dp_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0] frame_dp_q, frame_dp_d;

  // The dp bit rides alongside the committed sample. It never takes part in
  // change detection.
  always_comb begin
    prev_dp_d   = seg_q[0];
    shadow_dp_d = shadow_dp_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (do_commit && prev_sel_q[i]) shadow_dp_d[i] = prev_dp_q;
    end
    frame_dp_d  = load ? shadow_dp_q : frame_dp_q;
  end

  // Decimal-point registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_dp_q   <= 1'b0;
      shadow_dp_q <= '0;
      frame_dp_q  <= '0;
    end else begin
      prev_dp_q   <= prev_dp_d;
      shadow_dp_q <= shadow_dp_d;
      frame_dp_q  <= frame_dp_d;
    end
  end

  assign frame_dp = frame_dp_q;
`else
  // In this build the dp bit is sampled along with the bus but otherwise ignored.
  logic dp_unused;
  assign dp_unused = seg_q[0];
`endif

endmodule

// File: tb/tb_seg7_frame_capture.sv
// Directed testbench for seg7_frame_capture (NUM_DIGITS=2, STABLE_CYCLES=4).
// Inputs change on the falling edge, and outputs are checked there too.
// When built with SEG7_DP_CAPTURE_EN, frame_dp is also checked.
module tb_seg7_frame_capture;

  localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011;
  localparam logic [6:0] P7 = 7'b1110000, P8 = 7'b1111111, P9 = 7'b1111011;
  localparam logic [6:0] BLANK = 7'b0000000, UNK = 7'b1001001, UNK2 = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg_in;
  logic [1:0] dig_sel;
  logic [7:0] frame_digits;
  logic       frame_valid;
  logic       frame_ready;
  logic       err_pattern;
  logic       err_overflow;
  logic       err_clr;
`ifdef SEG7_DP_CAPTURE_EN
  logic [1:0] frame_dp;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_frame_capture #(.NUM_DIGITS(2), .STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .dig_sel      (dig_sel),
    .frame_digits (frame_digits),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .err_pattern  (err_pattern),
    .err_overflow (err_overflow),
    .err_clr      (err_clr)
`ifdef SEG7_DP_CAPTURE_EN
    ,
    .frame_dp     (frame_dp)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one digit on the bus and hold it for n clocks.
  task automatic drive(input logic [1:0] sel, input logic [6:0] pat, input logic dp, input int n);
    dig_sel = sel;
    seg_in  = {pat, dp};
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ready();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; seg_in = '0; dig_sel = '0; frame_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_digits", 32'(frame_digits), 32'h0000_00AA);
    chk("reset_valid", 32'(frame_valid), 32'd0);
    chk("reset_err_pattern", 32'(err_pattern), 32'd0);
    chk("reset_err_overflow", 32'(err_overflow), 32'd0);
    rst_n = 1'b1;

    // Basic frame: 3 on digit 0, 4 on digit 1, and the exact latency edge.
    drive(2'b01, P3, 1'b1, 6);
    drive(2'b10, P4, 1'b0, 6);
    chk("latency_not_early", 32'(frame_valid), 32'd0);
    @(negedge clk);
    chk("basic_valid", 32'(frame_valid), 32'd1);
    chk("basic_digits", 32'(frame_digits), 32'h43);
    repeat (3) @(negedge clk);
    chk("hold_valid", 32'(frame_valid), 32'd1);
    chk("hold_digits", 32'(frame_digits), 32'h43);
    pulse_ready();
    chk("accept_drop", 32'(frame_valid), 32'd0);

    // Glitching digit 0 never commits, so committing digit 1 cannot complete a frame.
    for (int k = 0; k < 5; k++) begin
      drive(2'b01, P1, 1'b0, 2);
      drive(2'b01, P7, 1'b0, 2);
    end
    chk("glitch_valid", 32'(frame_valid), 32'd0);
    drive(2'b10, BLANK, 1'b0, 7);
    chk("glitch_no_commit", 32'(frame_valid), 32'd0);

    // Unknown pattern on digit 0 completes the frame as AF.
    drive(2'b01, UNK, 1'b0, 7);
    chk("unk_valid", 32'(frame_valid), 32'd1);
    chk("unk_digits", 32'(frame_digits), 32'hAF);
    chk("unk_err_set", 32'(err_pattern), 32'd1);
    pulse_clr();
    chk("unk_err_clr", 32'(err_pattern), 32'd0);
    pulse_ready();
    chk("unk_accept", 32'(frame_valid), 32'd0);

    // Overflow: the second frame is dropped while the first is still pending.
    drive(2'b01, P5, 1'b0, 6);
    drive(2'b10, P2, 1'b0, 7);
    chk("ovf_first_valid", 32'(frame_valid), 32'd1);
    chk("ovf_first_digits", 32'(frame_digits), 32'h25);
    chk("ovf_not_yet", 32'(err_overflow), 32'd0);
    drive(2'b01, P7, 1'b0, 6);
    drive(2'b10, P9, 1'b0, 7);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk("ovf_retained", 32'(frame_digits), 32'h25);
    chk("ovf_valid_held", 32'(frame_valid), 32'd1);
    pulse_ready();
    chk("ovf_accept_drop", 32'(frame_valid), 32'd0);
    pulse_clr();
    chk("ovf_clr", 32'(err_overflow), 32'd0);

    // err_clr wins over an error set in the same cycle.
    drive(2'b01, P0, 1'b0, 6);
    drive(2'b10, P1, 1'b0, 7);
    chk("f10_digits", 32'(frame_digits), 32'h10);
    err_clr = 1'b1;
    drive(2'b01, UNK2, 1'b0, 6);
    err_clr = 1'b0;
    chk("clr_priority", 32'(err_pattern), 32'd0);

    // A multi-hot select never commits, so no frame completes (no overflow).
    drive(2'b11, P8, 1'b0, 10);
    chk("multihot_no_commit", 32'(err_overflow), 32'd0);
    drive(2'b01, UNK, 1'b0, 6);
    chk("recommit_err", 32'(err_pattern), 32'd1);
    chk("recommit_no_frame", 32'(err_overflow), 32'd0);

    // Asynchronous reset mid-frame.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_digits", 32'(frame_digits), 32'h0000_00AA);
    chk("async_rst_valid", 32'(frame_valid), 32'd0);
    chk("async_rst_err_pat", 32'(err_pattern), 32'd0);
    chk("async_rst_err_ovf", 32'(err_overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decimal-point frame: dp never changes the decoded digits.
    drive(2'b01, P8, 1'b1, 7);
    chk("dp_partial", 32'(frame_valid), 32'd0);
    drive(2'b10, P0, 1'b0, 7);
    chk("dp_valid", 32'(frame_valid), 32'd1);
    chk("dp_digits", 32'(frame_digits), 32'h08);
`ifdef SEG7_DP_CAPTURE_EN
    chk("dp_bits", 32'(frame_dp), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
